// File: rtl/banco_alu_param.sv
// Register bank + sequenced ALU (add/sub/shift-add mult/restoring div) with
// init/done handshake, external bank load and status flags.

module banco_alu_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module banco_alu_param #(
  parameter int WIDTH  = 8,
  parameter int NREG   = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              RegWrite,
  input  logic [1:0]        selector,
  input  logic [ADDR_W-1:0] addrRa,
  input  logic [ADDR_W-1:0] addrRb,
  input  logic [ADDR_W-1:0] addrW,
  input  logic              wr_ext_en,
  input  logic [WIDTH-1:0]  wr_ext_data,
  output logic [WIDTH-1:0]  result,
  output logic              negative,
  output logic              overflow,
  output logic              div_zero,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_DONE} state_t;

  typedef struct packed {
    logic [1:0]        op;
    logic              regwr;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [ADDR_W-1:0] rw;
  } req_t;

  state_t state, state_nx;
  req_t   req;

  logic [NREG-1:0][WIDTH-1:0] bank;
  logic [NREG-1:0]            reg_we;
  logic [WIDTH-1:0]           reg_d;
  logic                       ext_we, wb_we;

  logic [WIDTH-1:0]   a, b, rd_a, rd_b;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod, mcand, prod_nx;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   rem, quo, rem_nx, quo_nx;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic               last;

  // ---------------- register bank ----------------
  // Both write sources are state-exclusive, so a single data mux suffices.
  assign ext_we = (state == S_IDLE) && wr_ext_en;
  assign wb_we  = (state == S_DONE) && req.regwr && !div_zero;
  assign reg_d  = ext_we ? wr_ext_data : result;

  // Addresses at or above NREG match no instance, so those writes vanish.
  for (genvar i = 0; i < NREG; i++) begin : g_bank
    assign reg_we[i] = (ext_we && addrW  == ADDR_W'(i)) ||
                       (wb_we  && req.rw == ADDR_W'(i));
    banco_alu_reg #(.WIDTH(WIDTH)) u_reg (
      .clk (clk),
      .rst (rst),
      .we  (reg_we[i]),
      .d   (reg_d),
      .q   (bank[i])
    );
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (int'(req.ra) < NREG) rd_a = bank[req.ra];
    if (int'(req.rb) < NREG) rd_b = bank[req.rb];
  end

  // ---------------- control ----------------
  assign last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (init) state_nx = S_LOAD;
      S_LOAD: state_nx = S_EXEC;
      S_EXEC: if (!req.op[1] || last) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // ---------------- iterative step logic ----------------
  always_comb begin
    prod_nx = prod + (mplier[0] ? mcand : '0);
    // Remainder stays below the divisor, so the shifted value fits WIDTH+1.
    rem_sh  = {rem, quo[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, b});
    rem_nx  = rem_ge ? WIDTH'(rem_sh - {1'b0, b}) : rem_sh[WIDTH-1:0];
    quo_nx  = {quo[WIDTH-2:0], rem_ge};
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      req      <= '0;
      a        <= '0;
      b        <= '0;
      cnt      <= '0;
      prod     <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      quo      <= '0;
      result   <= '0;
      negative <= 1'b0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (init) req <= '{op: selector, regwr: RegWrite,
                                   ra: addrRa, rb: addrRb, rw: addrW};
        S_LOAD: begin
          a        <= rd_a;
          b        <= rd_b;
          cnt      <= '0;
          prod     <= '0;
          mcand    <= {{WIDTH{1'b0}}, rd_a};
          mplier   <= rd_b;
          rem      <= '0;
          quo      <= rd_a;
          result   <= '0;
          negative <= 1'b0;
          overflow <= 1'b0;
          div_zero <= 1'b0;
        end
        S_EXEC: begin
          case (req.op)
            2'b00: {overflow, result} <= {1'b0, a} + {1'b0, b};
            2'b01: begin
              if (a >= b) begin
                result   <= a - b;
                negative <= 1'b0;
              end else begin
                result   <= b - a;
                negative <= 1'b1;
              end
            end
            2'b10: begin
              prod   <= prod_nx;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
              cnt    <= cnt + CW'(1);
              if (last) begin
                result   <= prod_nx[WIDTH-1:0];
                overflow <= |prod_nx[2*WIDTH-1:WIDTH];
              end
            end
            default: begin
              rem <= rem_nx;
              quo <= quo_nx;
              cnt <= cnt + CW'(1);
              if (last) begin
                // Divide-by-zero still runs the full iteration count.
                if (b == '0) begin
                  result   <= '1;
                  div_zero <= 1'b1;
                end else begin
                  result   <= quo_nx;
                end
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_banco_alu_param.sv
// Directed bench for banco_alu_param (WIDTH=8, NREG=16): arithmetic, latency,
// busy handling, external load and mid-operation reset.

module tb_banco_alu_param;
  localparam int WIDTH  = 8;
  localparam int NREG   = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst, init, RegWrite, wr_ext_en;
  logic [1:0]        selector;
  logic [ADDR_W-1:0] addrRa, addrRb, addrW;
  logic [WIDTH-1:0]  wr_ext_data, result;
  logic              negative, overflow, div_zero, busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  banco_alu_param #(.WIDTH(WIDTH), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .init(init), .RegWrite(RegWrite), .selector(selector),
    .addrRa(addrRa), .addrRb(addrRb), .addrW(addrW), .wr_ext_en(wr_ext_en),
    .wr_ext_data(wr_ext_data), .result(result), .negative(negative),
    .overflow(overflow), .div_zero(div_zero), .busy(busy), .done(done)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; init = 1'b0; wr_ext_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic ext_load(input logic [ADDR_W-1:0] ad, input logic [WIDTH-1:0] d);
    @(negedge clk);
    addrW = ad; wr_ext_data = d; wr_ext_en = 1'b1;
    @(negedge clk);
    wr_ext_en = 1'b0;
  endtask

  // cyc = edges after the init-sampling edge until done is seen (64 = timeout)
  task automatic run_op(input logic [1:0] op, input logic [ADDR_W-1:0] ra, rb, rw,
                        input logic wr, output int cyc);
    @(negedge clk);
    selector = op; addrRa = ra; addrRb = rb; addrW = rw; RegWrite = wr; init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 64);
    @(posedge clk); #1;
  endtask

  task automatic peek(input logic [ADDR_W-1:0] ad, output logic [WIDTH-1:0] v);
    int c;
    run_op(2'b00, ad, 4'd0, 4'd0, 1'b0, c);
    v = result;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] v;
    do_reset();
    #1;
    tests++;
    if ({result, negative, overflow, div_zero, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got res=%0d n=%b o=%b dz=%b busy=%b done=%b want all 0",
               result, negative, overflow, div_zero, busy, done);
    end
    peek(4'd7, v);
    tests++;
    if (v !== 8'd0) begin fails++; $display("FAIL reset_bank: got %0d want 0", v); end
  endtask

  task automatic test_add();
    int c;
    logic [WIDTH-1:0] v;
    ext_load(4'd1, 8'd200);
    ext_load(4'd2, 8'd100);
    run_op(2'b00, 4'd1, 4'd2, 4'd3, 1'b1, c);
    tests++;
    if (c !== 2) begin fails++; $display("FAIL add_latency: got %0d want 2", c); end
    tests++;
    if ({result, overflow} !== {8'd44, 1'b1}) begin
      fails++; $display("FAIL add_result: got %0d ov=%b want 44 ov=1", result, overflow);
    end
    run_op(2'b00, 4'd3, 4'd0, 4'd0, 1'b0, c);
    tests++;
    if ({result, overflow} !== {8'd44, 1'b0}) begin
      fails++; $display("FAIL add_writeback: got %0d ov=%b want 44 ov=0", result, overflow);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (result !== 8'd44) begin fails++; $display("FAIL result_hold: got %0d want 44", result); end
  endtask

  task automatic test_sub();
    int c;
    run_op(2'b01, 4'd2, 4'd1, 4'd0, 1'b0, c);
    tests++;
    if ({result, negative, overflow} !== {8'd100, 1'b1, 1'b0}) begin
      fails++; $display("FAIL sub_neg: got %0d n=%b o=%b want 100 n=1 o=0", result, negative, overflow);
    end
    run_op(2'b01, 4'd1, 4'd2, 4'd0, 1'b0, c);
    tests++;
    if ({result, negative, c} !== {8'd100, 1'b0, 32'd2}) begin
      fails++; $display("FAIL sub_pos: got %0d n=%b lat=%0d want 100 n=0 lat=2", result, negative, c);
    end
  endtask

  task automatic test_mult();
    int c;
    ext_load(4'd4, 8'd20);
    ext_load(4'd5, 8'd15);
    run_op(2'b10, 4'd4, 4'd5, 4'd0, 1'b0, c);
    tests++;
    if (c !== 9) begin fails++; $display("FAIL mult_latency: got %0d want 9", c); end
    tests++;
    if ({result, overflow} !== {8'd44, 1'b1}) begin
      fails++; $display("FAIL mult_ovf: got %0d ov=%b want 44 ov=1", result, overflow);
    end
    run_op(2'b10, 4'd5, 4'd5, 4'd0, 1'b0, c);
    tests++;
    if ({result, overflow} !== {8'd225, 1'b0}) begin
      fails++; $display("FAIL mult_fit: got %0d ov=%b want 225 ov=0", result, overflow);
    end
  endtask

  task automatic test_div();
    int c;
    logic [WIDTH-1:0] v;
    run_op(2'b11, 4'd1, 4'd5, 4'd0, 1'b0, c);
    tests++;
    if ({result, div_zero, c} !== {8'd13, 1'b0, 32'd9}) begin
      fails++; $display("FAIL div_basic: got %0d dz=%b lat=%0d want 13 dz=0 lat=9", result, div_zero, c);
    end
    run_op(2'b11, 4'd1, 4'd0, 4'd6, 1'b1, c);
    tests++;
    if ({result, div_zero} !== {8'd255, 1'b1}) begin
      fails++; $display("FAIL div_zero: got %0d dz=%b want 255 dz=1", result, div_zero);
    end
    peek(4'd6, v);
    tests++;
    if (v !== 8'd0) begin fails++; $display("FAIL div_zero_nowb: got %0d want 0", v); end
    run_op(2'b11, 4'd2, 4'd4, 4'd7, 1'b1, c);
    peek(4'd7, v);
    tests++;
    if (v !== 8'd5) begin fails++; $display("FAIL div_wb: got %0d want 5", v); end
  endtask

  task automatic test_same_reg();
    int c;
    logic [WIDTH-1:0] v;
    run_op(2'b00, 4'd5, 4'd5, 4'd5, 1'b1, c);
    peek(4'd5, v);
    tests++;
    if (v !== 8'd30) begin fails++; $display("FAIL same_reg: got %0d want 30", v); end
  endtask

  task automatic test_load_and_init();
    int c;
    @(negedge clk);
    addrW = 4'd8; wr_ext_data = 8'd77; wr_ext_en = 1'b1;
    selector = 2'b00; addrRa = 4'd8; addrRb = 4'd0; RegWrite = 1'b0; init = 1'b1;
    @(negedge clk);
    wr_ext_en = 1'b0; init = 1'b0;
    c = 0;
    do begin @(posedge clk); #1; c++; end while (!done && c < 64);
    @(posedge clk); #1;
    tests++;
    if (result !== 8'd77) begin fails++; $display("FAIL load_with_init: got %0d want 77", result); end
  endtask

  task automatic test_busy_ignore();
    int ndone, done_at, busy_bad;
    logic [WIDTH-1:0] v;
    ndone = 0; done_at = 0; busy_bad = 0;
    @(negedge clk);
    selector = 2'b10; addrRa = 4'd4; addrRb = 4'd2; addrW = 4'd9; RegWrite = 1'b1; init = 1'b1;
    @(posedge clk);
    for (int cy = 1; cy <= 14; cy++) begin
      @(negedge clk);
      init = (cy == 3 || cy == 6);
      wr_ext_en = (cy == 4);
      selector = 2'b00; addrW = 4'd10; wr_ext_data = 8'd99;
      @(posedge clk); #1;
      if (done) begin ndone++; done_at = cy; end
      if (cy <= 9 && !busy) busy_bad++;
    end
    @(negedge clk);
    init = 1'b0; wr_ext_en = 1'b0;
    tests++;
    if ({ndone, done_at} !== {32'd1, 32'd9}) begin
      fails++; $display("FAIL busy_single_done: got %0d pulses at %0d want 1 at 9", ndone, done_at);
    end
    tests++;
    if (busy_bad !== 0 || busy !== 1'b0) begin
      fails++; $display("FAIL busy_level: got %0d low cycles, final busy=%b want 0 and 0", busy_bad, busy);
    end
    peek(4'd9, v);
    tests++;
    if (v !== 8'd208) begin fails++; $display("FAIL busy_wb: got %0d want 208", v); end
    peek(4'd10, v);
    tests++;
    if (v !== 8'd0) begin fails++; $display("FAIL busy_ext_ignored: got %0d want 0", v); end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    logic [WIDTH-1:0] v;
    seen = 0;
    @(negedge clk);
    selector = 2'b11; addrRa = 4'd1; addrRb = 4'd4; addrW = 4'd11; RegWrite = 1'b1; init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({busy, done, result} !== '0) begin
      fails++; $display("FAIL rst_mid_op: got busy=%b done=%b res=%0d want 0 0 0", busy, done, result);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int cy = 0; cy < 12; cy++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL rst_no_done: got %0d pulses want 0", seen); end
    peek(4'd1, v);
    tests++;
    if (v !== 8'd0) begin fails++; $display("FAIL rst_bank_r1: got %0d want 0", v); end
    peek(4'd11, v);
    tests++;
    if (v !== 8'd0) begin fails++; $display("FAIL rst_bank_r11: got %0d want 0", v); end
  endtask

  initial begin
    rst = 1'b0; init = 1'b0; RegWrite = 1'b0; wr_ext_en = 1'b0; selector = 2'b00;
    addrRa = '0; addrRb = '0; addrW = '0; wr_ext_data = '0;
    test_reset();
    test_add();
    test_sub();
    test_mult();
    test_div();
    test_same_reg();
    test_load_and_init();
    test_busy_ignore();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
